// File: rtl/sn_core_dispatcher_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sn_core_dispatcher_pkg
// Description : Shared definitions for the snooper core dispatcher: clog2 helper
//               macro, index-width derivation and default sizing constants.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package sn_core_dispatcher_pkg;

    // Default sizing of a dispatcher instance
    localparam int C_DEF_NUM_CORES   = 4;
    localparam int C_DEF_ADDR_WIDTH  = 8;
    localparam int C_DEF_DATA_WIDTH  = 64;
    localparam int C_DEF_INC_WIDTH   = `CLOG2(C_DEF_DATA_WIDTH / 8) + 1;

    // One-hot per-core vectors are exactly one bit per core
    localparam int C_DEF_ONEHOT_WIDTH = C_DEF_NUM_CORES;
    localparam int C_DEF_IDX_WIDTH    = `CLOG2(C_DEF_NUM_CORES);

    // Index width for a given core count; never narrower than one bit
    function automatic int sn_idx_width(input int num);
        return (num < 2) ? 1 : `CLOG2(num);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sn_core_dispatcher_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sn_core_dispatcher_if
// Description : Snooper packet-memory write port plus the buffer-ready
//               handshake. The snooper is the master, the dispatcher the slave.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

interface sn_core_dispatcher_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64,
    parameter int INC_WIDTH  = 4
);

    logic [ADDR_WIDTH-1:0] sn_addr;
    logic [DATA_WIDTH-1:0] sn_wr_data;
    logic                  sn_wr_en;
    logic [INC_WIDTH-1:0]  sn_byte_inc;
    logic                  sn_done;
    logic                  rdy_for_sn;
    logic                  rdy_for_sn_ack;

    modport master (
        output sn_addr,
        output sn_wr_data,
        output sn_wr_en,
        output sn_byte_inc,
        output sn_done,
        output rdy_for_sn_ack,
        input  rdy_for_sn
    );

    modport slave (
        input  sn_addr,
        input  sn_wr_data,
        input  sn_wr_en,
        input  sn_byte_inc,
        input  sn_done,
        input  rdy_for_sn_ack,
        output rdy_for_sn
    );

endinterface

`default_nettype wire

// File: rtl/sn_rr_pick.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sn_rr_pick
// Description : Combinational round-robin first-set finder. Returns the first
//               set request bit at or after the start pointer (wrapping),
//               optionally skipping one excluded index.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module sn_rr_pick #(
    parameter int N         = 4,
    parameter int IDX_WIDTH = 2
) (
    input  wire logic [N-1:0]         req,
    input  wire logic [IDX_WIDTH-1:0] start,
    input  wire logic [IDX_WIDTH-1:0] excl_idx,
    input  wire logic                 excl_vld,
    output logic      [IDX_WIDTH-1:0] grant_idx,
    output logic                      grant_vld
);

    // Walk the requests from the start pointer, first qualifying bit wins
    always_comb begin
        int                   base;
        int                   pos;
        logic [IDX_WIDTH-1:0] w_pos_idx;

        grant_idx = '0;
        grant_vld = 1'b0;
        // An out-of-range start pointer restarts the search at index 0
        base      = (int'(start) < N) ? int'(start) : 0;
        pos       = 0;
        w_pos_idx = '0;
        for (int k = 0; k < N; k++) begin
            pos = base + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            w_pos_idx = IDX_WIDTH'(pos);
            if (!grant_vld && req[w_pos_idx] &&
                !(excl_vld && (excl_idx == w_pos_idx))) begin
                grant_vld = 1'b1;
                grant_idx = w_pos_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sn_core_dispatcher.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sn_core_dispatcher
// Description : Shares one snooper write stream among NUM_CORES filter cores.
//               A round-robin search offers one ready buffer to the snooper;
//               once claimed, writes and the done strobe are routed to that
//               core with zero latency.
//               Optional statistics: define SN_DISPATCH_STATS_EN to add the
//               pkt_count and no_buf_cycles counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module sn_core_dispatcher
    import sn_core_dispatcher_pkg::*;
#(
    parameter int  NUM_CORES  = C_DEF_NUM_CORES,
    parameter int  ADDR_WIDTH = C_DEF_ADDR_WIDTH,
    parameter int  DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int  INC_WIDTH  = C_DEF_INC_WIDTH,
    localparam int IDX_WIDTH  = sn_idx_width(NUM_CORES)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    sn_core_dispatcher_if.slave        sn,
    input  wire logic [NUM_CORES-1:0]  core_rdy,
    output logic      [NUM_CORES-1:0]  core_ack,
    output logic      [ADDR_WIDTH-1:0] core_addr,
    output logic      [DATA_WIDTH-1:0] core_wr_data,
    output logic      [INC_WIDTH-1:0]  core_byte_inc,
    output logic      [NUM_CORES-1:0]  core_wr_en,
    output logic      [NUM_CORES-1:0]  core_done,
    output logic      [IDX_WIDTH-1:0]  active_idx,
    output logic                       active_vld
`ifdef SN_DISPATCH_STATS_EN
    ,
    output logic      [31:0]           pkt_count,
    output logic      [31:0]           no_buf_cycles
`endif
);

    logic                 r_cand_vld;
    logic [IDX_WIDTH-1:0] r_cand_idx;
    logic                 r_act_vld;
    logic [IDX_WIDTH-1:0] r_act_idx;
    logic [IDX_WIDTH-1:0] r_rr_ptr;

    logic                 w_pick_vld;
    logic [IDX_WIDTH-1:0] w_pick_idx;
    logic                 w_claim;
    logic [IDX_WIDTH-1:0] w_rr_next;

    // Search starts at the round-robin pointer and never re-offers the
    // buffer that is currently being written
    sn_rr_pick #(
        .N         (NUM_CORES),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_pick (
        .req       (core_rdy),
        .start     (r_rr_ptr),
        .excl_idx  (r_act_idx),
        .excl_vld  (r_act_vld),
        .grant_idx (w_pick_idx),
        .grant_vld (w_pick_vld)
    );

    assign w_claim   = r_cand_vld && sn.rdy_for_sn_ack;
    // Explicit wrap so non-power-of-two core counts never see an invalid index
    assign w_rr_next = (r_cand_idx == IDX_WIDTH'(NUM_CORES - 1)) ?
                       '0 : (r_cand_idx + IDX_WIDTH'(1));

    // Candidate / active ownership and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cand_vld <= 1'b0;
            r_cand_idx <= '0;
            r_act_vld  <= 1'b0;
            r_act_idx  <= '0;
            r_rr_ptr   <= '0;
        end else if (w_claim) begin
            // A claim wins over a same-cycle done: ownership hands over directly
            r_act_idx  <= r_cand_idx;
            r_act_vld  <= 1'b1;
            r_cand_vld <= 1'b0;
            r_rr_ptr   <= w_rr_next;
        end else begin
            if (r_act_vld && sn.sn_done) begin
                r_act_vld <= 1'b0;
            end
            // The candidate is frozen while offered; search only when idle
            if (!r_cand_vld && w_pick_vld) begin
                r_cand_vld <= 1'b1;
                r_cand_idx <= w_pick_idx;
            end
        end
    end

    assign sn.rdy_for_sn = r_cand_vld;
    assign active_idx    = r_act_idx;
    assign active_vld    = r_act_vld;

    // Data path is a pure broadcast; only the strobes are steered
    assign core_addr     = sn.sn_addr;
    assign core_wr_data  = sn.sn_wr_data;
    assign core_byte_inc = sn.sn_byte_inc;

    generate
        for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
            assign core_ack[i]   = w_claim && (r_cand_idx == IDX_WIDTH'(i));
            assign core_wr_en[i] = r_act_vld && sn.sn_wr_en &&
                                   (r_act_idx == IDX_WIDTH'(i));
            // Done goes to the owner sampled this cycle, before any handover
            assign core_done[i]  = r_act_vld && sn.sn_done &&
                                   (r_act_idx == IDX_WIDTH'(i));
        end
    endgenerate

`ifdef SN_DISPATCH_STATS_EN
    logic [31:0] r_pkt_count;
    logic [31:0] r_no_buf_cycles;

    // Saturating counters of routed packets and buffer-starved cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count     <= '0;
            r_no_buf_cycles <= '0;
        end else begin
            if (r_act_vld && sn.sn_done && (r_pkt_count != '1)) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
            if (!r_cand_vld && !r_act_vld && (r_no_buf_cycles != '1)) begin
                r_no_buf_cycles <= r_no_buf_cycles + 32'd1;
            end
        end
    end

    assign pkt_count     = r_pkt_count;
    assign no_buf_cycles = r_no_buf_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sn_core_dispatcher.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sn_core_dispatcher
// Description : Directed self-checking bench for sn_core_dispatcher (4 cores).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------

module tb_sn_core_dispatcher;

    localparam int NUM_CORES  = 4;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 64;
    localparam int INC_WIDTH  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_CORES-1:0]  core_rdy;
    logic [NUM_CORES-1:0]  core_ack;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [DATA_WIDTH-1:0] core_wr_data;
    logic [INC_WIDTH-1:0]  core_byte_inc;
    logic [NUM_CORES-1:0]  core_wr_en;
    logic [NUM_CORES-1:0]  core_done;
    logic [1:0]            active_idx;
    logic                  active_vld;
`ifdef SN_DISPATCH_STATS_EN
    logic [31:0]           pkt_count;
    logic [31:0]           no_buf_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    sn_core_dispatcher_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INC_WIDTH  (INC_WIDTH)
    ) sn_bus ();

    sn_core_dispatcher #(
        .NUM_CORES  (NUM_CORES),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INC_WIDTH  (INC_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sn            (sn_bus),
        .core_rdy      (core_rdy),
        .core_ack      (core_ack),
        .core_addr     (core_addr),
        .core_wr_data  (core_wr_data),
        .core_byte_inc (core_byte_inc),
        .core_wr_en    (core_wr_en),
        .core_done     (core_done),
        .active_idx    (active_idx),
        .active_vld    (active_vld)
`ifdef SN_DISPATCH_STATS_EN
        ,
        .pkt_count     (pkt_count),
        .no_buf_cycles (no_buf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1ns after the active edge; checks follow 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_bus();
        sn_bus.sn_addr        = '0;
        sn_bus.sn_wr_data     = '0;
        sn_bus.sn_wr_en       = 1'b0;
        sn_bus.sn_byte_inc    = '0;
        sn_bus.sn_done        = 1'b0;
        sn_bus.rdy_for_sn_ack = 1'b0;
    endtask

    task automatic wait_rdy(input string tag);
        int n = 0;
        while (!sn_bus.rdy_for_sn && n < 8) begin
            tick();
            n++;
        end
        chk_eq(tag, 64'(sn_bus.rdy_for_sn), 64'd1);
    endtask

    initial begin
        logic [NUM_CORES-1:0] exp_oh;
        logic                 any_wr;
        logic                 any_rdy;

        idle_bus();
        core_rdy = '0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();

        // Reset state
        chk_eq("rst_rdy",    64'(sn_bus.rdy_for_sn), 64'd0);
        chk_eq("rst_act",    64'(active_vld),        64'd0);
        chk_eq("rst_ack",    64'(core_ack),          64'd0);
        chk_eq("rst_wr_en",  64'(core_wr_en),        64'd0);
        chk_eq("rst_done",   64'(core_done),         64'd0);

        // Two ready cores: candidate appears one cycle later, core 0 first
        core_rdy = 4'b0101;
        settle();
        chk_eq("rdy_bubble", 64'(sn_bus.rdy_for_sn), 64'd0);
        tick();
        chk_eq("rdy_rise",   64'(sn_bus.rdy_for_sn), 64'd1);
        sn_bus.rdy_for_sn_ack = 1'b1;
        settle();
        chk_eq("ack_c0",     64'(core_ack),          64'h1);
        tick();
        sn_bus.rdy_for_sn_ack = 1'b0;
        core_rdy = 4'b0100;
        settle();
        chk_eq("act_idx0",   64'(active_idx),        64'd0);
        chk_eq("act_vld0",   64'(active_vld),        64'd1);
        chk_eq("rdy_after",  64'(sn_bus.rdy_for_sn), 64'd0);

        // Three-flit packet to core 0 with broadcast data path
        for (int a = 0; a < 3; a++) begin
            sn_bus.sn_wr_en    = 1'b1;
            sn_bus.sn_addr     = 8'(a);
            sn_bus.sn_wr_data  = 64'hA5A5_0000_0000_0000 | 64'(a);
            sn_bus.sn_byte_inc = 4'd8;
            settle();
            chk_eq($sformatf("flit%0d_wr_en", a), 64'(core_wr_en),   64'h1);
            chk_eq($sformatf("flit%0d_addr", a),  64'(core_addr),    64'(a));
            chk_eq($sformatf("flit%0d_data", a),  core_wr_data,      64'hA5A5_0000_0000_0000 | 64'(a));
            chk_eq($sformatf("flit%0d_inc", a),   64'(core_byte_inc), 64'd8);
            tick();
        end
        sn_bus.sn_wr_en = 1'b0;
        sn_bus.sn_done  = 1'b1;
        settle();
        chk_eq("done_c0",    64'(core_done),         64'h1);
        tick();
        sn_bus.sn_done = 1'b0;
        settle();
        chk_eq("release0",   64'(active_vld),        64'd0);
        chk_eq("cand2_rdy",  64'(sn_bus.rdy_for_sn), 64'd1);

        // Claim core 2 (next after 0 in round-robin order)
        sn_bus.rdy_for_sn_ack = 1'b1;
        settle();
        chk_eq("ack_c2",     64'(core_ack),          64'h4);
        tick();
        sn_bus.rdy_for_sn_ack = 1'b0;
        core_rdy = 4'b0001;
        settle();
        chk_eq("act_idx2",   64'(active_idx),        64'd2);
        tick();
        chk_eq("cand0_rdy",  64'(sn_bus.rdy_for_sn), 64'd1);

        // Last flit with done and claim together: done to old owner, ack to new
        sn_bus.sn_wr_en       = 1'b1;
        sn_bus.sn_addr        = 8'd6;
        sn_bus.sn_done        = 1'b1;
        sn_bus.rdy_for_sn_ack = 1'b1;
        settle();
        chk_eq("sim_done",   64'(core_done),         64'h4);
        chk_eq("sim_wr_en",  64'(core_wr_en),        64'h4);
        chk_eq("sim_ack",    64'(core_ack),          64'h1);
        tick();
        idle_bus();
        core_rdy = 4'b0000;
        settle();
        chk_eq("sim_act_idx", 64'(active_idx),       64'd0);
        chk_eq("sim_act_vld", 64'(active_vld),       64'd1);
        sn_bus.sn_done = 1'b1;
        settle();
        chk_eq("done_c0b",   64'(core_done),         64'h1);
        tick();
        sn_bus.sn_done = 1'b0;
        settle();
        chk_eq("release0b",  64'(active_vld),        64'd0);

        // No buffers for 10 cycles while the snooper keeps writing
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sn_bus.sn_wr_en = 1'b1;
        any_wr  = 1'b0;
        any_rdy = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sn_bus.sn_addr = 8'(c);
            settle();
            any_wr  = any_wr  | (|core_wr_en);
            any_rdy = any_rdy | sn_bus.rdy_for_sn;
            tick();
        end
        sn_bus.sn_wr_en = 1'b0;
        chk_eq("nobuf_wr_en", 64'(any_wr),           64'd0);
        chk_eq("nobuf_rdy",   64'(any_rdy),          64'd0);
`ifdef SN_DISPATCH_STATS_EN
        chk_eq("nobuf_cnt",   64'(no_buf_cycles),    64'd10);
`endif

        // All cores ready: eight packets claim in strict rotation
        core_rdy = 4'b1111;
        for (int p = 0; p < 8; p++) begin
            exp_oh = NUM_CORES'(1) << (p % NUM_CORES);
            wait_rdy($sformatf("rr%0d_rdy", p));
            sn_bus.rdy_for_sn_ack = 1'b1;
            settle();
            chk_eq($sformatf("rr%0d_ack", p), 64'(core_ack), 64'(exp_oh));
            tick();
            sn_bus.rdy_for_sn_ack = 1'b0;
            sn_bus.sn_done        = 1'b1;
            settle();
            chk_eq($sformatf("rr%0d_done", p), 64'(core_done), 64'(exp_oh));
            tick();
            sn_bus.sn_done = 1'b0;
        end
`ifdef SN_DISPATCH_STATS_EN
        settle();
        chk_eq("pkt_cnt",     64'(pkt_count),        64'd8);
`endif

        // Reset in the middle of a packet
        rst = 1'b1;
        tick();
        rst = 1'b0;
        core_rdy = 4'b0001;
        wait_rdy("mid_rdy");
        sn_bus.rdy_for_sn_ack = 1'b1;
        tick();
        sn_bus.rdy_for_sn_ack = 1'b0;
        core_rdy = 4'b0000;
        sn_bus.sn_wr_en = 1'b1;
        settle();
        chk_eq("mid_wr_en",  64'(core_wr_en),        64'h1);
        rst = 1'b1;
        tick();
        chk_eq("mid_act",    64'(active_vld),        64'd0);
        chk_eq("mid_rdy0",   64'(sn_bus.rdy_for_sn), 64'd0);
        chk_eq("mid_wr_en0", 64'(core_wr_en),        64'd0);
        rst = 1'b0;
        idle_bus();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sn_core_dispatcher.md
Name: sn_core_dispatcher

Overview:
- Shares one snooper write stream among NUM_CORES parallel filter cores, each with its own packet buffer.
- Sits between the snooper's packet-memory interface (addr/data/wr_en/byte_inc/done plus the rdy_for_sn/rdy_for_sn_ack handshake) and the per-core packet memories.
- Selects the next ready core round-robin and presents it to the snooper as a single ready signal.
- Routes the snooper's writes and done strobe to whichever core claimed the current packet.

Parameters:
- NUM_CORES, 4: number of cores/packet buffers, 2..16.
- ADDR_WIDTH, 8: packet memory address width.
- DATA_WIDTH, 64: packet memory data width.
- INC_WIDTH, 4: byte_inc width, equal to clog2(DATA_WIDTH/8)+1.
- IDX_WIDTH, clog2(NUM_CORES): derived, do not set.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sn_addr  in  ADDR_WIDTH  snooper write address.
- sn_wr_data  in  DATA_WIDTH  snooper write data.
- sn_wr_en  in  1  snooper write strobe.
- sn_byte_inc  in  INC_WIDTH  snooper byte increment.
- sn_done  in  1  snooper end-of-packet strobe.
- rdy_for_sn  out  1  to snooper: a buffer is available.
- rdy_for_sn_ack  in  1  from snooper: buffer claimed this cycle if rdy_for_sn is high.
- core_rdy  in  NUM_CORES  per-core buffer-ready, held high until acked.
- core_ack  out  NUM_CORES  one-hot claim pulse to a core.
- core_addr  out  ADDR_WIDTH  broadcast address.
- core_wr_data  out  DATA_WIDTH  broadcast data.
- core_byte_inc  out  INC_WIDTH  broadcast byte increment.
- core_wr_en  out  NUM_CORES  one-hot write strobe.
- core_done  out  NUM_CORES  one-hot done strobe.
- active_idx  out  IDX_WIDTH  core currently owning the snooper.
- active_vld  out  1  active_idx is meaningful.

Behaviour:
- Registered state:
  - cand_vld and cand_idx: the buffer offered to the snooper.
  - act_vld and act_idx: the buffer currently being written.
  - rr_ptr: the index searched from next.
- Reset values: all state registers 0. rdy_for_sn, core_ack, core_wr_en and core_done are all 0.
- Output mapping:
  - rdy_for_sn = cand_vld.
  - core_ack[cand_idx] = cand_vld && rdy_for_sn_ack (combinational pulse).
- Claim: on cand_vld && rdy_for_sn_ack:
  - act_idx <= cand_idx, act_vld <= 1.
  - cand_vld <= 0.
  - rr_ptr <= cand_idx+1, wrapping modulo NUM_CORES.
- Candidate search:
  - Runs each cycle in which cand_vld is 0.
  - Picks the first set bit of core_rdy at or after rr_ptr, wrapping, and excluding act_idx when act_vld is 1.
  - The result is registered, so rdy_for_sn rises 1 cycle after a claim or after a core_rdy rises.
  - If no bit qualifies, cand_vld stays 0.
- Candidate stability: once cand_vld is 1, cand_idx holds until claimed. A core_rdy bit dropping while that core is the candidate is a contract violation and is ignored.
- Routing:
  - core_wr_en[act_idx] = act_vld && sn_wr_en.
  - core_done[act_idx] = act_vld && sn_done.
  - Address, data and byte_inc are broadcast unmodified.
  - Routing is purely combinational, with zero latency.
- Release: on act_vld && sn_done, act_vld <= 0, unless a claim occurs in the same cycle.
- Simultaneous done and claim (the snooper asserts both on a last flit):
  - core_done goes to the old act_idx.
  - act_idx then switches to cand_idx, and act_vld stays 1.
- Writes with act_vld=0 are discarded. The snooper already counts such drops.
- Back-to-back single-flit packets: the 1-cycle search bubble can leave rdy_for_sn low at the second packet's end. That packet is dropped by the snooper. This is accepted behaviour.
- Reset mid-packet: all state clears the next cycle. Cores receive no done strobe; core-side reset is their responsibility.
- Wrap-around: rr_ptr wraps from NUM_CORES-1 to 0. For non-power-of-two NUM_CORES, indices >= NUM_CORES are never produced.

Optional Feature:
- Macro: SN_DISPATCH_STATS_EN.
- When defined:
  - Adds an output pkt_count of 32 bits, counting sn_done pulses routed to a valid act_idx.
  - Adds an output no_buf_cycles of 32 bits, counting cycles with cand_vld=0 and act_vld=0.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - The CLOG2 macro.
  - IDX_WIDTH derivation.
  - Localparams for one-hot width.
- Sub-module sn_rr_pick: combinational round-robin first-set finder.
  - Inputs: req vector, start pointer, exclude index/valid.
  - Outputs: grant index and valid.
  - Reusable by other arbiters.

Test Plan:
- Reset, then core_rdy=4'b0101 -> rdy_for_sn=1 at cycle 2, cand_idx=0. Ack -> core_ack=4'b0001, active_idx=0, next candidate 2.
- 3-flit packet to core 0 -> core_wr_en[0] pulses 3×, and addresses 0,1,2 appear on core_addr. sn_done -> core_done=4'b0001, then active_vld=0.
- Last flit with done and ack in the same cycle, active 0, candidate 2 -> core_done[0]=1, core_ack[2]=1, active_idx=2 the next cycle.
- core_rdy=0 for 10 cycles with snooper writes -> rdy_for_sn=0, core_wr_en=0. With the macro defined, no_buf_cycles=10.
- All cores ready, 8 packets -> claim order 0,1,2,3,0,1,2,3.
- rst asserted mid-packet -> active_vld=0, rdy_for_sn=0, core_wr_en=0 the next cycle.
